// File: rtl/regincr_pipe_pkg.sv
// Shared constants and helpers for the parametrised registered-incrementer pipeline.
// Imported by the stage, the top level and the bench.
package regincr_pipe_pkg;

  localparam int REGINCR_WRAP = 0;
  localparam int REGINCR_SAT  = 1;

  // Occupancy needs to represent 0..nstages inclusive.
  function automatic int occ_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/regincr_pipe_stage.sv
// One val/rdy register stage that adds a constant increment to the message as it is captured,
// either wrapping or clamping at the all-ones value.
module regincr_pipe_stage
  import regincr_pipe_pkg::*;
#(
  parameter int p_nbits    = 8,
  parameter int p_incr     = 1,
  parameter int p_saturate = REGINCR_WRAP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_val_i,
  input  logic [p_nbits-1:0] up_msg_i,
  input  logic               dn_rdy_i,
  output logic               rdy_o,
  output logic               val_o,
  output logic [p_nbits-1:0] msg_o
);

  localparam logic [p_nbits:0] IncrExt = (p_nbits + 1)'(p_incr);
  localparam bit SatMode = (p_saturate != REGINCR_WRAP);

  logic               val_q, val_d;
  logic [p_nbits-1:0] data_q, data_d;
  logic [p_nbits:0]   sum;
  logic               go;

  // The extra carry bit of the sum tells us when saturation must clamp.
  always_comb begin
    rdy_o  = !val_q || dn_rdy_i;
    go     = rdy_o && up_val_i;
    sum    = {1'b0, up_msg_i} + IncrExt;
    val_d  = val_q;
    data_d = data_q;
    if (go) begin
      val_d  = 1'b1;
      data_d = (SatMode && sum[p_nbits]) ? '1 : sum[p_nbits-1:0];
    end else if (rdy_o) begin
      val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

  assign val_o = val_q;
  assign msg_o = data_q;

endmodule

// File: rtl/regincr_pipe.sv
// Chain of p_nstages incrementing register stages with a combinational ready chain,
// so a full pipe still streams one message per cycle when the sink is ready.
module regincr_pipe
  import regincr_pipe_pkg::*;
#(
  parameter int p_nbits    = 8,
  parameter int p_nstages  = 2,
  parameter int p_incr     = 1,
  parameter int p_saturate = REGINCR_WRAP
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [p_nbits-1:0]                in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_nbits-1:0]                out_msg,
  output logic [occ_width(p_nstages)-1:0]   occupancy
);

  localparam int OccW = occ_width(p_nstages);

  logic [p_nstages:0]   stageRdy;
  logic [p_nstages-1:0] stageVal;
  logic [p_nbits-1:0]   stageMsg [p_nstages];
  logic                 inFire, outFire;
  logic [OccW-1:0]      occ_q, occ_d;

  assign stageRdy[p_nstages] = out_rdy;

  generate
    for (genvar i = 0; i < p_nstages; i++) begin : g_stage
      logic               upVal;
      logic [p_nbits-1:0] upMsg;

      if (i == 0) begin : g_head
        assign upVal = in_val;
        assign upMsg = in_msg;
      end else begin : g_body
        assign upVal = stageVal[i-1];
        assign upMsg = stageMsg[i-1];
      end

      regincr_pipe_stage #(
        .p_nbits   (p_nbits),
        .p_incr    (p_incr),
        .p_saturate(p_saturate)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .up_val_i(upVal),
        .up_msg_i(upMsg),
        .dn_rdy_i(stageRdy[i+1]),
        .rdy_o   (stageRdy[i]),
        .val_o   (stageVal[i]),
        .msg_o   (stageMsg[i])
      );
    end
  endgenerate

  assign in_rdy  = stageRdy[0];
  assign out_val = stageVal[p_nstages-1];
  assign out_msg = stageMsg[p_nstages-1];

  // Messages only enter or leave at the ends, so tracking the two handshakes
  // keeps the count equal to the number of valid stages after every edge.
  always_comb begin
    inFire  = in_val && in_rdy;
    outFire = out_val && out_rdy;
    occ_d   = occ_q;
    if (inFire && !outFire) begin
      occ_d = occ_q + OccW'(1);
    end else if (!inFire && outFire) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_regincr_pipe.sv
// Directed bench for regincr_pipe: four configurations share one clock and reset,
// each driven by a linear sequence of steps with hand-computed expectations.
module tb_regincr_pipe;
  import regincr_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // A: defaults (8b, 2 stages, +1, wrap)
  logic       aInVal, aInRdy, aOutVal, aOutRdy;
  logic [7:0] aInMsg, aOutMsg;
  logic [1:0] aOcc;

  // B: 8b, 3 stages, +0x40, saturating
  logic       bInVal, bInRdy, bOutVal, bOutRdy;
  logic [7:0] bInMsg, bOutMsg;
  logic [1:0] bOcc;

  // C: 16b, 4 stages, +3, wrap
  logic        cInVal, cInRdy, cOutVal, cOutRdy;
  logic [15:0] cInMsg, cOutMsg;
  logic [2:0]  cOcc;

  // D: 8b, 1 stage, +0 (pure elastic buffer)
  logic       dInVal, dInRdy, dOutVal, dOutRdy;
  logic [7:0] dInMsg, dOutMsg;
  logic [0:0] dOcc;

  regincr_pipe #(.p_nbits(8), .p_nstages(2), .p_incr(1), .p_saturate(REGINCR_WRAP)) dutA (
    .clk(clk), .reset(reset), .in_val(aInVal), .in_rdy(aInRdy), .in_msg(aInMsg),
    .out_val(aOutVal), .out_rdy(aOutRdy), .out_msg(aOutMsg), .occupancy(aOcc));

  regincr_pipe #(.p_nbits(8), .p_nstages(3), .p_incr(8'h40), .p_saturate(REGINCR_SAT)) dutB (
    .clk(clk), .reset(reset), .in_val(bInVal), .in_rdy(bInRdy), .in_msg(bInMsg),
    .out_val(bOutVal), .out_rdy(bOutRdy), .out_msg(bOutMsg), .occupancy(bOcc));

  regincr_pipe #(.p_nbits(16), .p_nstages(4), .p_incr(3), .p_saturate(REGINCR_WRAP)) dutC (
    .clk(clk), .reset(reset), .in_val(cInVal), .in_rdy(cInRdy), .in_msg(cInMsg),
    .out_val(cOutVal), .out_rdy(cOutRdy), .out_msg(cOutMsg), .occupancy(cOcc));

  regincr_pipe #(.p_nbits(8), .p_nstages(1), .p_incr(0), .p_saturate(REGINCR_WRAP)) dutD (
    .clk(clk), .reset(reset), .in_val(dInVal), .in_rdy(dInRdy), .in_msg(dInMsg),
    .out_val(dOutVal), .out_rdy(dOutRdy), .out_msg(dOutMsg), .occupancy(dOcc));

  // Directed vectors and their hand-computed results
  logic [7:0] t1In  [3] = '{8'h00, 8'h05, 8'hFE};
  logic [7:0] t1Exp [3] = '{8'h02, 8'h07, 8'h00};
  logic [1:0] t1Occ [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
  logic [7:0] bIn   [4] = '{8'h90, 8'h10, 8'hFF, 8'h00};
  logic [7:0] bExp  [4] = '{8'hFF, 8'hD0, 8'hFF, 8'hC0};
  logic [7:0] dIn   [4] = '{8'h00, 8'hA5, 8'hFF, 8'h3C};

  logic [15:0] sb [$];
  int sent, rcvd, cyc;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives DUT A's inputs for the coming edge.
  task automatic applyStimulus(input logic v, input logic [7:0] m, input logic r);
    aInVal  = v;
    aInMsg  = m;
    aOutRdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    bInVal = 1'b0; bInMsg = '0; bOutRdy = 1'b1;
    cInVal = 1'b0; cInMsg = '0; cOutRdy = 1'b1;
    dInVal = 1'b0; dInMsg = '0; dOutRdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_outVal", aOutVal, 1'b0);
    checkOutput("rst_outMsg", aOutMsg, 8'h00);
    checkOutput("rst_occ",    aOcc,    2'd0);
    checkOutput("rst_inRdy",  aInRdy,  1'b1);
    checkOutput("rst_cOcc",   cOcc,    3'd0);
    checkOutput("rst_dOutVal", dOutVal, 1'b0);

    // Back-to-back stream through A, two-cycle latency
    for (int k = 0; k < 4; k++) begin
      if (k < 3) applyStimulus(1'b1, t1In[k], 1'b1);
      else       applyStimulus(1'b0, 8'h00, 1'b1);
      tick();
      checkOutput("t1_occ", aOcc, t1Occ[k]);
      if (k == 0) begin
        checkOutput("t1_latency", aOutVal, 1'b0);
      end else begin
        checkOutput("t1_outVal", aOutVal, 1'b1);
        checkOutput("t1_outMsg", aOutMsg, t1Exp[k-1]);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("t1_drainVal", aOutVal, 1'b0);
    checkOutput("t1_drainOcc", aOcc, 2'd0);

    // Backpressure on A: sink stalls for five edges
    applyStimulus(1'b1, 8'h10, 1'b0);
    tick();
    checkOutput("bp_inRdy1", aInRdy, 1'b1);
    checkOutput("bp_occ1",   aOcc,   2'd1);
    applyStimulus(1'b1, 8'h20, 1'b0);
    tick();
    checkOutput("bp_inRdyFull", aInRdy,  1'b0);
    checkOutput("bp_occFull",   aOcc,    2'd2);
    checkOutput("bp_outMsg",    aOutMsg, 8'h12);
    applyStimulus(1'b1, 8'h30, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput("bp_holdMsg", aOutMsg, 8'h12);
      checkOutput("bp_holdRdy", aInRdy,  1'b0);
      checkOutput("bp_holdOcc", aOcc,    2'd2);
    end
    applyStimulus(1'b1, 8'h30, 1'b1);
    #1;
    checkOutput("bp_inRdyRelease", aInRdy, 1'b1);
    tick();
    checkOutput("bp_out2", aOutMsg, 8'h22);
    checkOutput("bp_occBoth", aOcc, 2'd2);
    applyStimulus(1'b1, 8'h40, 1'b1);
    tick();
    checkOutput("bp_out3", aOutMsg, 8'h32);
    checkOutput("bp_occBoth2", aOcc, 2'd2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("bp_out4", aOutMsg, 8'h42);
    checkOutput("bp_occ3", aOcc, 2'd1);
    tick();
    checkOutput("bp_empty", aOutVal, 1'b0);
    checkOutput("bp_occ4",  aOcc,    2'd0);

    // Reset with two messages in flight on A
    applyStimulus(1'b1, 8'h50, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h60, 1'b0);
    tick();
    checkOutput("mr_occBefore", aOcc, 2'd2);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    reset = 1'b0;
    checkOutput("mr_outVal", aOutVal, 1'b0);
    checkOutput("mr_occ",    aOcc,    2'd0);
    checkOutput("mr_inRdy",  aInRdy,  1'b1);
    for (int s = 0; s < 4; s++) begin
      tick();
      checkOutput("mr_noGhost", aOutVal, 1'b0);
    end

    // Saturating 3-stage B
    for (int k = 0; k < 6; k++) begin
      bInVal = (k < 4);
      bInMsg = (k < 4) ? bIn[k] : 8'h00;
      tick();
      if (k < 2) begin
        checkOutput("sat_latency", bOutVal, 1'b0);
      end else begin
        checkOutput("sat_outVal", bOutVal, 1'b1);
        checkOutput("sat_outMsg", bOutMsg, bExp[k-2]);
      end
    end
    bInVal = 1'b0;

    // Elastic single-stage D at full rate
    for (int k = 0; k < 4; k++) begin
      dInVal = 1'b1;
      dInMsg = dIn[k];
      tick();
      checkOutput("el_inRdy",  dInRdy,  1'b1);
      checkOutput("el_outVal", dOutVal, 1'b1);
      checkOutput("el_outMsg", dOutMsg, dIn[k]);
    end
    dInVal = 1'b0;
    tick();
    checkOutput("el_drain", dOutVal, 1'b0);

    // Random val/rdy toggling on C with an in-order scoreboard
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 200 && cyc < 3000) begin
      cInVal  = (sent < 200) && ($urandom_range(0, 9) < 7);
      cInMsg  = 16'($urandom);
      cOutRdy = ($urandom_range(0, 9) < 7);
      #1;
      if (cInVal && cInRdy) begin
        sb.push_back(cInMsg + 16'd12);
        sent++;
      end
      if (cOutVal && cOutRdy) begin
        if (sb.size() == 0) begin
          checkOutput("rnd_spurious", 32'(sb.size()), 32'd1);
        end else begin
          checkOutput("rnd_order", cOutMsg, sb.pop_front());
          rcvd++;
        end
      end
      cyc++;
      tick();
    end
    cInVal = 1'b0;
    checkOutput("rnd_allDelivered", rcvd, 200);
    checkOutput("rnd_sbDrained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regincr_pipe.md
Name: regincr_pipe

Overview:
- Parametrised successor to the single-stage 8-bit registered incrementer.
- Chain of p_nstages register+increment stages, each adding p_incr, with latency-insensitive val/rdy handshaking and backpressure.
- Each stage selects wrap-around or saturating arithmetic.
- Sits between val/rdy test sources and sinks; it is the datapath exercise for stall propagation in the tutorial pipeline.

Parameters:
- p_nbits, 8, message width in bits (>=2).
- p_nstages, 2, number of pipeline stages (1..8).
- p_incr, 1, unsigned increment added per stage (0 .. 2^p_nbits-1).
- p_saturate, 0, 0 = modulo-2^p_nbits wrap; 1 = clamp at 2^p_nbits-1.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- in_val  in  1  input message valid.
- in_rdy  out  1  input accepted this cycle when in_val && in_rdy.
- in_msg  in  p_nbits  input message.
- out_val  out  1  output message valid.
- out_rdy  in  1  sink ready; transfer when out_val && out_rdy.
- out_msg  out  p_nbits  incremented message.
- occupancy  out  $clog2(p_nstages+1)  number of valid stages (in-flight messages).

Behaviour:
- Interface: reset is clk-synchronous, active-high; clock is clk.
- State per stage i (0 = input side, p_nstages-1 = output side): val_r[i] (1 bit), data_r[i] (p_nbits).
- Reset:
  - all val_r and data_r are 0 on the clock edge with reset high.
  - out_val=0, out_msg=0, occupancy=0, in_rdy=1 after reset deasserts.
  - reset mid-operation discards all in-flight messages; no output handshake fires in the reset cycle.
- Stage advance:
  - go[i] = rdy[i] && upstream valid, where upstream valid = in_val for stage 0 and val_r[i-1] otherwise.
  - rdy[i] = !val_r[i] || rdy[i+1], with rdy[p_nstages] = out_rdy.
  - This is a combinational ready chain, so a full pipeline with out_rdy=1 accepts one message per cycle. No bubbles are required.
- On go[i]: data_r[i] <= f(upstream data), val_r[i] <= 1.
- Else if rdy[i]: val_r[i] <= 0.
- Else: hold (stall).
- in_rdy = rdy[0]. out_val = val_r[last]. out_msg = data_r[last].
- Increment function f(x):
  - p_saturate=0: (x + p_incr) mod 2^p_nbits.
  - p_saturate=1: min(x + p_incr, 2^p_nbits-1), computed at p_nbits+1 width.
  - Saturation is applied per stage, so the total equals repeated application, not a single sum.
- Latency: a message accepted at edge t appears on out_msg after edge t+p_nstages-1, i.e. valid in the cycle after the p_nstages-th edge, absent stalls. Throughput is 1 msg/cycle.
- Order: strictly FIFO; no message is dropped or duplicated.
- Stall:
  - out_rdy=0 with the pipeline full holds every stage; in_rdy=0; out_msg is stable while out_val && !out_rdy.
  - Partially full pipelines compress bubbles before deasserting in_rdy.
- Simultaneous in and out handshake when full: allowed. Occupancy is unchanged.
- Occupancy: popcount of val_r, updated registered.
- p_incr=0: pure elastic pipeline; out_msg equals in_msg.

Decomposition:
- Shared package/header holds:
  - the mode constants REGINCR_WRAP=0 and REGINCR_SAT=1;
  - the width helper for occupancy.
- Natural sub-module: regincr_pipe_stage, one val/rdy register stage with the f() adder and saturation mux. It is instantiated p_nstages times in a generate loop.
- The top level owns the ready chain and occupancy.

Test Plan:
- Defaults (8b, 2 stages, incr 1, wrap), out_rdy=1; send 0x00, 0x05, 0xFE back-to-back -> out 0x02, 0x07, 0x00 in order, 1 per cycle, first out_val in the cycle after the 2nd edge following acceptance.
- p_saturate=1, p_incr=0x40, 3 stages; send 0x90 -> 0xFF; send 0x10 -> 0xD0.
- Backpressure: out_rdy=0 for 5 cycles while sending 4 msgs on 2 stages -> in_rdy drops after 2 accepted, occupancy=2, out_msg stable. Then out_rdy=1 -> all 4 delivered in order with no loss.
- Random in_val/out_rdy toggling, 200 msgs, p_nbits=16, p_nstages=4, p_incr=3 -> scoreboard matches (x+12) mod 2^16 in order.
- Reset asserted with 2 messages in flight -> next cycle out_val=0, occupancy=0, in_rdy=1; the messages never appear.
- p_nstages=1, p_incr=0 -> out_msg equals in_msg one cycle later; full-rate throughput with out_rdy=1.
